mdu_issue_ctrl: RTL and testbench
=================================

// Module: mdu_issue_ctrl
// PURPOSE
//  Issue/sequencing controller for the multiply-divide unit (MDU) in the pipelined MIPS core.
//  - Accepts MD instructions from the E stage and pulses a start to the MDU datapath.
//  - Times the MULT/DIV latency and pulses the HI/LO write at completion.
//  - Generates the D-stage stall while the MDU is busy.
//  - Suppresses issue of flushed instructions (exception/interrupt).
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after start for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles after start for DIV/DIVU (>=1)
//  CNT_W        4   latency counter width; must hold max(MULT_CYCLES,DIV_CYCLES)
// PORTS
//  clk          in   1  single clock, rising edge
//  reset        in   1  asynchronous, active-high; clears all state
//  i_Op         in   4  E-stage MD op: 0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTHI,8 MTLO; 9-15 = none
//  i_Valid      in   1  E-stage instruction is real (not a bubble)
//  i_Flush      in   1  exception/interrupt this cycle; E-stage op must not take effect
//  i_DIsMd      in   1  D-stage instruction is any MD op (codes 1-8)
//  o_Start      out  1  one-cycle pulse: MDU latches operands and mode
//  o_StartMode  out  4  op code accompanying o_Start (1-4); 0 when o_Start=0
//  o_Busy       out  1  MDU occupied (start cycle plus run cycles)
//  o_Stall      out  1  stall D stage (and freeze F/D)
//  o_HiLoWe     out  1  one-cycle pulse: commit MDU result to HI/LO
//  o_HiWe       out  1  MTHI write pulse
//  o_LoWe       out  1  MTLO write pulse
// BEHAVIOUR
//  - Reset: state IDLE, counter 0; all outputs 0 while reset is high and in the first cycle after release.
//  - Issue condition: iss = (state==IDLE) & i_Valid & ~i_Flush & (i_Op in 1..4).
//  - States:
//    - IDLE: on iss, go to RUN; cnt <= MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4).
//    - RUN: cnt decrements each cycle; at cnt==1, o_HiLoWe=1 and next state is IDLE.
//  - Outputs (combinational from state and inputs):
//    - o_Start = iss; o_StartMode = iss ? i_Op : 0.
//    - o_Busy = iss | (state==RUN).
//    - o_Stall = i_DIsMd & o_Busy.
//  - Timing: start in cycle T gives o_Busy high for T..T+N, o_HiLoWe high in T+N, IDLE in T+N+1.
//    - Earliest next issue is T+N+1.
//  - MT ops:
//    - o_HiWe = (state==IDLE) & i_Valid & ~i_Flush & (i_Op==7).
//    - o_LoWe = the same with i_Op==8.
//    - Both are single-cycle pulses; no state change.
//  - MF ops (5, 6) and codes 0, 9-15: no action, no state change.
//  - Flush:
//    - Blocks issue and MT writes only in the cycle it is asserted.
//    - An op already in RUN completes normally; o_HiLoWe is still generated, because it is architecturally committed.
//  - MD op in E while RUN (stall violation): ignored; no restart, no MT write, counter undisturbed.
//  - MD op in E in the completion cycle (cnt==1): also ignored.
//  - Reset mid-RUN: immediate return to IDLE; no o_HiLoWe is produced for the aborted op.
//  - i_Valid=0 with a nonzero i_Op: treated as none.
// STRUCTURE
//  - Shared package mdu_pkg:
//    - op code localparams (MD_NONE..MD_MTLO);
//    - default latencies;
//    - state encoding (ST_IDLE, ST_RUN);
//    - helper function is_md_start(op).
//  - Sub-module mdu_latency_counter:
//    - loadable down-counter (load, value, en);
//    - outputs last = (cnt==1).
//  - Top level holds the 1-bit state register and the output decode.
// TESTING
//  - Reset: assert reset mid-cycle -> every output is 0 immediately (async); after release, o_Busy=0 and o_Stall=0.
//  - MULT issue:
//    - Stimulus: i_Op=1, i_Valid=1 for 1 cycle at T.
//    - Response: o_Start=1 and o_StartMode=1 at T; o_Busy=1 for T..T+5; o_HiLoWe=1 only at T+5; o_Busy=0 at T+6.
//  - DIVU with D-stage stall:
//    - Stimulus: i_Op=4 at T, with i_DIsMd=1 held throughout.
//    - Response: o_Stall=1 for T..T+10, o_HiLoWe at T+10, o_Stall=0 at T+11.
//    - A second i_Op=3 injected at T+3 causes no restart (o_HiLoWe is still at T+10).
//  - Flush:
//    - i_Op=2 with i_Flush=1 -> no o_Start, o_Busy stays 0.
//    - i_Op=7 with i_Flush=1 -> o_HiWe=0.
//    - i_Flush=1 at T+2 of a running MULT -> o_HiLoWe still at T+5.
//  - MT and MF ops in IDLE:
//    - i_Op=7 -> o_HiWe pulse, 1 cycle.
//    - i_Op=8 -> o_LoWe pulse.
//    - i_Op=5, 6 or 12 -> no output activity.
//  - Reset mid-op: start DIV at T, pulse reset at T+4 -> IDLE, o_Busy=0, and no o_HiLoWe at T+10.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the MDU issue controller.
//   - MD op codes as carried on the E-stage op bus
//   - default MULT/DIV latencies and counter width
//   - controller state encoding
//   - op classification helpers
package mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // True for the ops that occupy the MDU datapath (MULT, MULTU, DIV, DIVU).
  function automatic logic is_md_start(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  // True for the multiply flavours; everything else that starts is a divide.
  function automatic logic is_md_mult(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mdu_latency_counter.sv
// mdu_latency_counter: loadable down-counter timing an MDU operation.
// Ports:
//   clk, reset  clock and asynchronous active-high reset (clears the count)
//   load        load 'value' this cycle (takes priority over en)
//   value       latency to load
//   en          decrement by one (saturates at zero)
//   last        count equals one: final cycle of the operation
module mdu_latency_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             en,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement while enabled and nonzero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (en && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issue/sequencing controller for the multiply-divide unit.
// Accepts E-stage MD ops, pulses the MDU start, times MULT/DIV latency,
// pulses the HI/LO commit, drives the D-stage stall and the MTHI/MTLO
// write strobes. Flushed E-stage ops never issue.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   i_Op, i_Valid         E-stage MD op code and validity
//   i_Flush               exception/interrupt: E-stage op must not act
//   i_DIsMd               D-stage instruction is an MD op
//   o_Start, o_StartMode  start pulse and op code (1-4) for the MDU
//   o_Busy, o_Stall       MDU occupied, stall request to D stage
//   o_HiLoWe              commit MDU result to HI/LO
//   o_HiWe, o_LoWe        MTHI / MTLO write strobes
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_Op,
  input  logic       i_Valid,
  input  logic       i_Flush,
  input  logic       i_DIsMd,
  output logic       o_Start,
  output logic [3:0] o_StartMode,
  output logic       o_Busy,
  output logic       o_Stall,
  output logic       o_HiLoWe,
  output logic       o_HiWe,
  output logic       o_LoWe
);

  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

  md_state_e        st_q;
  md_state_e        st_d;
  logic             blank_q;   // high through reset and the first cycle after it
  logic             blank_d;
  logic             act;
  logic             accept;    // E-stage op may take effect (IDLE, valid, not flushed)
  logic             iss;
  logic             running;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_last;

  // Outputs stay quiet while reset is high (async) and for one cycle after.
  assign act = ~reset & ~blank_q;

  // Next-state, counter control and output decode.
  always_comb begin
    st_d        = st_q;
    blank_d     = 1'b0;
    accept      = 1'b0;
    iss         = 1'b0;
    running     = 1'b0;
    cnt_load    = 1'b0;
    cnt_value   = {CNT_W{1'b0}};
    o_Start     = 1'b0;
    o_StartMode = 4'd0;
    o_Busy      = 1'b0;
    o_Stall     = 1'b0;
    o_HiLoWe    = 1'b0;
    o_HiWe      = 1'b0;
    o_LoWe      = 1'b0;
    if (act) begin
      case (st_q)
        ST_IDLE: begin
          accept = i_Valid & ~i_Flush;
          iss    = accept & is_md_start(i_Op);
          if (iss) begin
            st_d      = ST_RUN;
            cnt_load  = 1'b1;
            cnt_value = is_md_mult(i_Op) ? MULT_LAT : DIV_LAT;
          end else begin
            st_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          // E-stage ops are ignored here; a flush cannot cancel a committed op.
          running = 1'b1;
          if (cnt_last) begin
            st_d = ST_IDLE;
          end else begin
            st_d = ST_RUN;
          end
        end
        default: begin
          st_d = ST_IDLE;
        end
      endcase
    end else begin
      st_d = ST_IDLE;
    end
    o_Start     = iss;
    o_StartMode = iss ? i_Op : 4'd0;
    o_Busy      = iss | running;
    o_Stall     = i_DIsMd & (iss | running);
    o_HiLoWe    = running & cnt_last;
    o_HiWe      = accept & (i_Op == MD_MTHI);
    o_LoWe      = accept & (i_Op == MD_MTLO);
  end

  // State and post-reset blanking registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= ST_IDLE;
      blank_q <= 1'b1;
    end else begin
      st_q    <= st_d;
      blank_q <= blank_d;
    end
  end

  mdu_latency_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .value (cnt_value),
    .en    (running),
    .last  (cnt_last)
  );

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl: a driver applies one input vector per
// cycle and pushes the reference model's expected outputs; a monitor on the
// falling edge pops and compares against the DUT.
module tb_mdu_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] i_Op = 4'd0;
  logic       i_Valid = 1'b0;
  logic       i_Flush = 1'b0;
  logic       i_DIsMd = 1'b0;
  logic       o_Start;
  logic [3:0] o_StartMode;
  logic       o_Busy;
  logic       o_Stall;
  logic       o_HiLoWe;
  logic       o_HiWe;
  logic       o_LoWe;

  typedef struct packed {
    logic        start;
    logic [3:0]  mode;
    logic        busy;
    logic        stall;
    logic        hilowe;
    logic        hiwe;
    logic        lowe;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: an op started at cycle T completes (commits) at T+N.
  int   run_end  = -1;
  bit   blank    = 1'b1;

  mdu_issue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .i_Op        (i_Op),
    .i_Valid     (i_Valid),
    .i_Flush     (i_Flush),
    .i_DIsMd     (i_DIsMd),
    .o_Start     (o_Start),
    .o_StartMode (o_StartMode),
    .o_Busy      (o_Busy),
    .o_Stall     (o_Stall),
    .o_HiLoWe    (o_HiLoWe),
    .o_HiWe      (o_HiWe),
    .o_LoWe      (o_LoWe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] c,
                       input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, c, got, want);
    end
  endtask

  // Monitor: compare every presented cycle against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("start",  e.cyc, {3'b000, o_Start},  {3'b000, e.start});
      check("mode",   e.cyc, o_StartMode,        e.mode);
      check("busy",   e.cyc, {3'b000, o_Busy},   {3'b000, e.busy});
      check("stall",  e.cyc, {3'b000, o_Stall},  {3'b000, e.stall});
      check("hilowe", e.cyc, {3'b000, o_HiLoWe}, {3'b000, e.hilowe});
      check("hiwe",   e.cyc, {3'b000, o_HiWe},   {3'b000, e.hiwe});
      check("lowe",   e.cyc, {3'b000, o_LoWe},   {3'b000, e.lowe});
    end
  end

  // Apply one cycle of stimulus just after the rising edge and record expectation.
  task automatic step(input int op, input bit valid, input bit flush,
                      input bit dismd, input bit rst);
    exp_t e;
    bit   running, idle, acc, iss;
    int   n;
    @(posedge clk);
    #1;
    reset   = rst;
    i_Op    = 4'(op);
    i_Valid = valid;
    i_Flush = flush;
    i_DIsMd = dismd;
    e = '0;
    e.cyc = 32'(cyc);
    if (rst) begin
      run_end = -1;
      blank   = 1'b1;
    end else if (blank) begin
      blank = 1'b0;
    end else begin
      running  = (run_end >= 0) && (cyc <= run_end);
      idle     = !running;
      acc      = idle && valid && !flush;
      iss      = acc && (op >= 1) && (op <= 4);
      e.start  = iss;
      e.mode   = iss ? 4'(op) : 4'd0;
      e.busy   = iss || running;
      e.stall  = dismd && e.busy;
      e.hilowe = running && (cyc == run_end);
      e.hiwe   = acc && (op == 7);
      e.lowe   = acc && (op == 8);
      if (e.hilowe) run_end = -1;
      if (iss) begin
        n = (op <= 2) ? 5 : 10;
        run_end = cyc + n;
      end
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle_cycles(input int n, input bit dismd);
    for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0, dismd, 1'b0);
  endtask

  initial begin
    // Reset, then the blank cycle after release.
    step(1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(7, 1'b1, 1'b0, 1'b1, 1'b1);
    step(7, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_cycles(2, 1'b0);

    // MULT: busy T..T+5, commit at T+5.
    step(1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(7, 1'b0);

    // DIVU with D-stage MD op held; a DIV injected at T+3 must be ignored.
    step(4, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_cycles(2, 1'b1);
    step(3, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_cycles(9, 1'b1);

    // Flushed MULTU and MTHI take no effect.
    step(2, 1'b1, 1'b1, 1'b0, 1'b0);
    step(7, 1'b1, 1'b1, 1'b0, 1'b0);
    // Flush during a running MULT does not cancel it.
    step(1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8, 1'b1, 1'b1, 1'b0, 1'b0);
    step(7, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(3, 1'b0);

    // MT/MF and out-of-range codes in IDLE; invalid op ignored.
    step(7, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5, 1'b1, 1'b0, 1'b1, 1'b0);
    step(6, 1'b1, 1'b0, 1'b0, 1'b0);
    step(12, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0, 1'b1, 1'b0);

    // DIV aborted by reset at T+4: no commit afterwards.
    step(3, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(3, 1'b0);
    step(0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_cycles(10, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      step(int'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) == 0));
    end
    idle_cycles(12, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
